matrix_sub_seq: RTL and testbench
=================================

Name: matrix_sub_seq

Overview:
- Sequencer that streams an N-row matrix pair through the 8-lane, 16-bit element-wise subtract datapath, one 128-bit row per accepted beat.
- Sits between the operand row source (A/B buffers) and the result sink.
- Handles the command (start/row count), input and output valid/ready handshakes, a 2-entry result buffer, a row counter, last-row tagging and a completion pulse.

Parameters:
- ROW_W, 8, width of row-count command and counters (max rows = 2^ROW_W-1)
- LANES, 8, elements per row (fixed at 8; kept for package/bench use)
- EW, 16, element width in bits

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  command strobe, sampled only in IDLE
- num_rows  input  ROW_W  rows in job, captured with start
- busy  output  1  high in any state except IDLE
- in_valid  input  1  operand row valid
- in_ready  output  1  operand row accepted when in_valid&&in_ready
- in_a  input  128  minuend row; lane i at bits [127-16i -: 16]
- in_b  input  128  subtrahend row, same packing
- out_valid  output  1  result row valid
- out_ready  input  1  sink accepts result
- out_data  output  128  lane i = in_a lane i - in_b lane i, mod 2^16
- out_borrow  output  8  bit i set when lane i of a < lane i of b (unsigned); bit 7 is lane 0
- out_last  output  1  marks final row of job
- done  output  1  one-cycle pulse when final row has left the output

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; counters=0; buffer emptied; busy=0, in_ready=0, out_valid=0, out_data=0, out_borrow=0, out_last=0, done=0.
- Reset mid-job: aborts immediately; buffered rows are discarded; no done pulse.
- States:
  - IDLE: start=1 captures num_rows.
    - num_rows=0 -> DONE.
    - num_rows>0 -> RUN.
  - RUN: accept rows. When accepted count reaches num_rows -> DRAIN.
  - DRAIN: in_ready=0. When the buffer empties (last row handshaken) -> DONE.
  - DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- start while busy is ignored; num_rows is held constant for the whole job.
- in_ready = (state==RUN) && (acc_cnt < num_rows) && (buffer has a free slot this cycle).
  - in_ready may assert in the same cycle an entry drains, i.e. when the buffer is full and out_ready=1.
- Datapath:
  - Combinational per-lane subtract with borrow. The result, borrow and last flag are written into the 2-entry FIFO on the accept edge.
  - Latency: the row appears on out_valid the cycle after acceptance if the buffer was empty.
  - Sustained throughput is 1 row/cycle when out_ready stays high.
- out_last=1 only on the row whose accept index == num_rows-1.
- Output rules: out_valid/out_data/out_borrow/out_last are stable while out_valid=1 && out_ready=0. Data is zero when the buffer is empty.
- Wrap: 0x0000 - 0x0001 = 0xFFFF with borrow=1. Equal lanes give 0 with borrow=0.
- Simultaneous push and pop on a full buffer: both occur and occupancy is unchanged.
- in_valid in IDLE/DRAIN/DONE is never accepted.

Decomposition:
- Package matrix_sub_pkg holds: LANES, EW, ROW_BITS=LANES*EW, state enum {IDLE,RUN,DRAIN,DONE}, a lane-slice helper function (index i -> bit offset 127-16i).
- One sub-module, matrix_sub_lanes: purely combinational. Inputs are two 128-bit rows; outputs are the 128-bit difference and the 8-bit borrow vector.
- The FSM, counters and 2-entry FIFO live in matrix_sub_seq.

Test Plan:
- Reset then start with num_rows=1; row a lanes all 0x0010, b lanes all 0x0003, out_ready=1 -> one beat: out_data all lanes 0x000D, out_borrow=0x00, out_last=1; done pulses 2 cycles after acceptance; busy returns 0.
- Wrap: lane0 a=0x0000 b=0x0001, lane7 a=0xFFFF b=0xFFFF, other lanes a=5 b=9 -> lane0 0xFFFF, lane7 0x0000, others 0xFFFC; out_borrow=0b1111_1110 (lane0..6 set).
- Backpressure: num_rows=4, in_valid held high, out_ready=0 -> exactly 2 rows accepted, then in_ready=0. Raise out_ready -> remaining rows stream 1/cycle in order; out_last only on row 3; one done pulse.
- num_rows=0 -> no in_ready assertion; done pulses the cycle after start; busy high for that 1 cycle.
- start asserted while in RUN with num_rows=7 -> ignored; job completes with the original count; only one done pulse.
- Mid-job reset: rst asserted after 2 of 5 rows accepted with out_ready=0 -> next cycle out_valid=0, busy=0, no done. A fresh start with num_rows=1 then completes normally.

Source files
------------

// File: rtl/matrix_sub_pkg.sv
// Shared constants, state encoding and lane-packing helper for the row subtract sequencer.
package matrix_sub_pkg;

   localparam int LANES    = 8;
   localparam int EW       = 16;
   localparam int ROW_BITS = LANES * EW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Lane 0 sits in the most significant slot of a row.
   function automatic int lane_msb(input int i);
      return ROW_BITS - 1 - EW * i;
   endfunction

endpackage

// File: rtl/matrix_sub_lanes.sv
// Purely combinational 8-lane unsigned subtract; each lane also reports whether it borrowed.
module matrix_sub_lanes
   import matrix_sub_pkg::*;
(
   input  logic [ROW_BITS-1:0] i_a,
   input  logic [ROW_BITS-1:0] i_b,
   output logic [ROW_BITS-1:0] o_diff,
   output logic [LANES-1:0]    o_borrow
);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [EW:0] w_d;

      // The extra top bit of the widened difference is the borrow out.
      assign w_d = {1'b0, i_a[lane_msb(g) -: EW]} - {1'b0, i_b[lane_msb(g) -: EW]};
      assign o_diff[lane_msb(g) -: EW] = w_d[EW-1:0];
      assign o_borrow[LANES-1-g]       = w_d[EW];
   end

endmodule

// File: rtl/matrix_sub_seq.sv
// Streams a job of num_rows operand rows through the lane subtractor into a 2-entry result FIFO.
module matrix_sub_seq
   import matrix_sub_pkg::*;
#(
   parameter int ROW_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ROW_W-1:0]    num_rows,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ROW_BITS-1:0] in_a,
   input  logic [ROW_BITS-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ROW_BITS-1:0] out_data,
   output logic [LANES-1:0]    out_borrow,
   output logic                out_last,
   output logic                done
);

   state_t              r_state;
   logic [ROW_W-1:0]    r_num_rows;
   logic [ROW_W-1:0]    r_acc_cnt;
   logic [ROW_BITS-1:0] r_mem_data   [2];
   logic [LANES-1:0]    r_mem_borrow [2];
   logic                r_mem_last   [2];
   logic                r_wr_ptr;
   logic                r_rd_ptr;
   logic [1:0]          r_count;

   logic [ROW_BITS-1:0] w_diff;
   logic [LANES-1:0]    w_borrow;
   logic [ROW_W-1:0]    w_acc_next;
   logic                w_push;
   logic                w_pop;

   matrix_sub_lanes u_lanes (
      .i_a      (in_a),
      .i_b      (in_b),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   // Both ports use valid/ready: a beat transfers on a rising edge where valid && ready;
   // the producer holds its payload stable until then, and ready may depend on the
   // sink's ready (a full buffer can take a new row in the same cycle one leaves).
   assign in_ready   = (r_state == RUN) && (r_acc_cnt < r_num_rows)
                       && ((r_count != 2'd2) || out_ready);
   assign out_valid  = (r_count != 2'd0);
   assign w_push     = in_valid && in_ready;
   assign w_pop      = out_valid && out_ready;
   assign w_acc_next = r_acc_cnt + ROW_W'(1);

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);

   always_comb begin
      out_data   = '0;
      out_borrow = '0;
      out_last   = 1'b0;
      if (out_valid) begin
         out_data   = r_mem_data[r_rd_ptr];
         out_borrow = r_mem_borrow[r_rd_ptr];
         out_last   = r_mem_last[r_rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_num_rows <= '0;
         r_acc_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_num_rows <= num_rows;
                  r_acc_cnt  <= '0;
                  r_state    <= (num_rows == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_push) begin
                  r_acc_cnt <= w_acc_next;
                  if (w_acc_next == r_num_rows) r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Leave as the final entry is handshaken so done follows it by one cycle.
               if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr]   <= w_diff;
            r_mem_borrow[r_wr_ptr] <= w_borrow;
            r_mem_last[r_wr_ptr]   <= (w_acc_next == r_num_rows);
            r_wr_ptr               <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_sub_seq.sv
// Directed-vector bench for matrix_sub_seq: one task per scenario with inline checks.
module tb_matrix_sub_seq;
   import matrix_sub_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [7:0]          num_rows = '0;
   logic                busy;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [ROW_BITS-1:0] in_a = '0;
   logic [ROW_BITS-1:0] in_b = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [ROW_BITS-1:0] out_data;
   logic [LANES-1:0]    out_borrow;
   logic                out_last;
   logic                done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   matrix_sub_seq #(.ROW_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_rows   (num_rows),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_borrow (out_borrow),
      .out_last   (out_last),
      .done       (done)
   );

   function automatic logic [ROW_BITS-1:0] fill(input logic [EW-1:0] v);
      return {LANES{v}};
   endfunction

   task automatic start_job(input logic [7:0] n);
      @(negedge clk);
      start    = 1'b1;
      num_rows = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({busy, in_ready, out_valid, out_last, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected %b", {busy, in_ready, out_valid, out_last, done}, 5'b0);
      end
      checks++;
      if (out_data !== '0 || out_borrow !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h expected 0/0", out_data, out_borrow);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      start_job(8'd1);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
      in_a = fill(16'h0010);
      in_b = fill(16'h0003);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== fill(16'h000D)) begin
         errors++;
         $display("FAIL basic_data: got v=%b %h expected v=1 %h", out_valid, out_data, fill(16'h000D));
      end
      checks++;
      if (out_borrow !== 8'h00 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL basic_flags: got borrow=%h last=%b expected 00/1", out_borrow, out_last);
      end
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: got done=%b in_ready=%b expected 0/0", done, in_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL basic_done: got done=%b busy=%b v=%b d=%h expected 1/1/0/0", done, busy, out_valid, out_data);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got done=%b busy=%b expected 0/0", done, busy);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      start_job(8'd1);
      in_a = {16'h0000, {6{16'h0005}}, 16'hFFFF};
      in_b = {16'h0001, {6{16'h0009}}, 16'hFFFF};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_data !== {16'hFFFF, {6{16'hFFFC}}, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_data: got %h expected %h", out_data, {16'hFFFF, {6{16'hFFFC}}, 16'h0000});
      end
      checks++;
      if (out_borrow !== 8'hFE) begin errors++; $display("FAIL wrap_borrow: got %h expected fe", out_borrow); end
      checks++;
      if (out_last !== 1'b1) begin errors++; $display("FAIL wrap_last: got %b expected 1", out_last); end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_timeout: busy never dropped, got busy=%b expected 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [ROW_BITS-1:0] exp_q[$];
      logic [ROW_BITS-1:0] exp_d;
      int sent, got, dones;
      sent = 0; got = 0; dones = 0;
      out_ready = 1'b0;
      in_b = fill(16'h0001);
      start_job(8'd4);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a = fill(16'h0100 + 16'(sent));
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(fill(16'h00FF + 16'(sent)));
            sent++;
         end
         @(negedge clk);
      end
      in_a = fill(16'h0100 + 16'(sent));
      #1;
      checks++;
      if (sent != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: got accepted=%0d in_ready=%b expected 2/0", sent, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== fill(16'h00FF) || out_last !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold: got v=%b d=%h last=%b expected 1 %h 0", out_valid, out_data, out_last, fill(16'h00FF));
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 20; i++) begin
         if (i > 0) begin
            @(negedge clk);
            in_a = fill(16'h0100 + 16'(sent));
            #1;
         end
         if (!busy) break;
         if (done) dones++;
         if (out_valid && out_ready) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (out_data !== exp_d) begin
               errors++;
               $display("FAIL bp_row%0d: got %h expected %h", got, out_data, exp_d);
            end
            checks++;
            if (out_last !== (got == 3)) begin
               errors++;
               $display("FAIL bp_last%0d: got %b expected %b", got, out_last, (got == 3));
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(fill(16'h00FF + 16'(sent)));
            sent++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || sent != 4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: got out=%0d in=%0d busy=%b expected 4/4/0", got, sent, busy);
      end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", dones); end
   endtask

   task automatic test_zero_rows();
      @(negedge clk);
      start    = 1'b1;
      num_rows = 8'd0;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_idle_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: got done=%b busy=%b in_ready=%b expected 1/1/0", done, busy, in_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_idle: got done=%b busy=%b v=%b expected 0/0/0", done, busy, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_start_ignored();
      int sent, got, dones;
      sent = 0; got = 0; dones = 0;
      out_ready = 1'b1;
      in_b = fill(16'h0100);
      start_job(8'd7);
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         start    = (i == 3);
         num_rows = (i == 3) ? 8'd3 : 8'd7;
         in_a     = fill(16'h0200 + 16'(sent));
         #1;
         if (!busy) break;
         if (done) dones++;
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== fill(16'h0100 + 16'(got)) || out_last !== (got == 6)) begin
               errors++;
               $display("FAIL ign_row%0d: got %h last=%b expected %h last=%b", got, out_data, out_last,
                        fill(16'h0100 + 16'(got)), (got == 6));
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (got != 7 || sent != 7 || dones != 1) begin
         errors++;
         $display("FAIL ign_count: got out=%0d in=%0d done=%0d expected 7/7/1", got, sent, dones);
      end
   endtask

   task automatic test_mid_reset();
      int sent;
      sent = 0;
      out_ready = 1'b0;
      in_a = fill(16'h0030);
      in_b = fill(16'h0010);
      start_job(8'd5);
      in_valid = 1'b1;
      for (int i = 0; i < 10 && sent < 2; i++) begin
         #1;
         if (in_valid && in_ready) sent++;
         @(negedge clk);
      end
      checks++;
      if (sent != 2) begin errors++; $display("FAIL mr_accept: got %0d expected 2", sent); end
      rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mr_abort: got v=%b busy=%b done=%b expected 0/0/0", out_valid, busy, done);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mr_quiet: got done=%b v=%b expected 0/0", done, out_valid);
      end
      start_job(8'd1);
      in_a = fill(16'h0007);
      in_b = fill(16'h0009);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_data !== fill(16'hFFFE) || out_borrow !== 8'hFF || out_last !== 1'b1) begin
         errors++;
         $display("FAIL mr_row: got %h b=%h last=%b expected %h b=ff last=1", out_data, out_borrow, out_last, fill(16'hFFFE));
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL mr_done: got %b expected 1", done); end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mr_idle: got busy=%b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_rows();
      test_start_ignored();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
